// File: rtl/bidi_register_bank.sv
// Bank of DEPTH registers sharing one tri-state bus: load from bus, drive onto bus,
// and (when BIDI_BANK_COUNT_EN is defined) count up/down by STEP with a wrap flag.
module bidi_register_bank #(
  parameter int BUS_WIDTH  = 16,
  parameter int DEPTH      = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int STEP       = 1,
  parameter int DIRECT_IDX = 0
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [SEL_WIDTH-1:0] SEL,
  input  logic                 RW,
  input  logic                 ENABLE,
  input  logic                 COUNT,
  input  logic                 DOWN,
  inout  wire  [BUS_WIDTH-1:0] DATA,
  output logic [BUS_WIDTH-1:0] DIRECT_OUT,
  output logic                 CARRY
);

  logic [BUS_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]     sel_hot;
  logic                 sel_ok;
  logic [BUS_WIDTH-1:0] sel_val;
  logic                 drive_en;
  logic                 do_load;
  logic                 do_count;
  logic [BUS_WIDTH-1:0] count_val;
  logic                 count_wrap;

  // Out-of-range SEL leaves sel_hot empty, so the bus reads zero and nothing updates.
  always_comb begin
    sel_hot = '0;
    sel_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (SEL == SEL_WIDTH'(i)) begin
        sel_hot[i] = 1'b1;
        sel_val    = regs[i];
      end
    end
  end

  assign sel_ok = |sel_hot;

  // Reset releases the bus immediately, ahead of the clearing edge.
  assign drive_en = ENABLE & RW & ~RESET;
  assign DATA     = drive_en ? sel_val : {BUS_WIDTH{1'bz}};

  assign do_load  = ENABLE & ~RW & sel_ok;

`ifdef BIDI_BANK_COUNT_EN
  localparam int EXT_W = BUS_WIDTH + 1;
  localparam logic [BUS_WIDTH:0] STEP_EXT = EXT_W'(STEP);

  // The extra top bit is the carry on an up count and the borrow on a down count.
  logic [BUS_WIDTH:0] count_ext;
  assign count_ext  = DOWN ? ({1'b0, sel_val} - STEP_EXT)
                           : ({1'b0, sel_val} + STEP_EXT);
  assign count_val  = count_ext[BUS_WIDTH-1:0];
  assign count_wrap = count_ext[BUS_WIDTH];
  assign do_count   = COUNT & ~(ENABLE & ~RW) & sel_ok;
`else
  logic unused_count;
  assign unused_count = COUNT ^ DOWN;
  assign count_val    = sel_val;
  assign count_wrap   = 1'b0;
  assign do_count     = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      CARRY <= 1'b0;
    end else if (do_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_hot[i]) begin
          regs[i] <= DATA;
        end
      end
      CARRY <= 1'b0;
    end else if (do_count) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_hot[i]) begin
          regs[i] <= count_val;
        end
      end
      CARRY <= count_wrap;
    end else begin
      CARRY <= 1'b0;
    end
  end

  assign DIRECT_OUT = regs[DIRECT_IDX];

endmodule

// File: tb/tb_bidi_register_bank.sv
// Directed bench for bidi_register_bank: a STEP=1 bank with 3-bit SEL and a STEP=4 bank
// with DIRECT_IDX=1; count expectations follow BIDI_BANK_COUNT_EN.
module tb_bidi_register_bank;

`ifdef BIDI_BANK_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  a_sel = '0;
  logic        a_rw = 1'b0, a_en = 1'b0, a_cnt = 1'b0, a_down = 1'b0, a_oe = 1'b0;
  logic [15:0] a_drv = '0;
  wire  [15:0] a_data;
  logic [15:0] a_direct;
  logic        a_carry;
  assign a_data = a_oe ? a_drv : 16'hzzzz;

  logic [0:0]  b_sel = '0;
  logic        b_rw = 1'b0, b_en = 1'b0, b_cnt = 1'b0, b_down = 1'b0, b_oe = 1'b0;
  logic [15:0] b_drv = '0;
  wire  [15:0] b_data;
  logic [15:0] b_direct;
  logic        b_carry;
  assign b_data = b_oe ? b_drv : 16'hzzzz;

  bidi_register_bank #(
    .BUS_WIDTH(16), .DEPTH(4), .SEL_WIDTH(3), .STEP(1), .DIRECT_IDX(0)
  ) u_dut_a (
    .CLOCK(clk), .RESET(rst), .SEL(a_sel), .RW(a_rw), .ENABLE(a_en),
    .COUNT(a_cnt), .DOWN(a_down), .DATA(a_data), .DIRECT_OUT(a_direct), .CARRY(a_carry)
  );

  bidi_register_bank #(
    .BUS_WIDTH(16), .DEPTH(2), .SEL_WIDTH(1), .STEP(4), .DIRECT_IDX(1)
  ) u_dut_b (
    .CLOCK(clk), .RESET(rst), .SEL(b_sel), .RW(b_rw), .ENABLE(b_en),
    .COUNT(b_cnt), .DOWN(b_down), .DATA(b_data), .DIRECT_OUT(b_direct), .CARRY(b_carry)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after an edge.
  task automatic a_set(input logic en, rw, input logic [2:0] sel,
                       input logic cnt, down, oe, input logic [15:0] drv);
    @(negedge clk);
    a_en = en; a_rw = rw; a_sel = sel; a_cnt = cnt; a_down = down; a_oe = oe; a_drv = drv;
  endtask

  task automatic a_cycle(input logic en, rw, input logic [2:0] sel,
                         input logic cnt, down, oe, input logic [15:0] drv);
    a_set(en, rw, sel, cnt, down, oe, drv);
    @(posedge clk);
    #1;
  endtask

  task automatic a_peek(input logic [2:0] sel, output logic [15:0] val);
    a_set(1'b1, 1'b1, sel, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1 val = a_data;
  endtask

  task automatic b_set(input logic en, rw, input logic [0:0] sel,
                       input logic cnt, down, oe, input logic [15:0] drv);
    @(negedge clk);
    b_en = en; b_rw = rw; b_sel = sel; b_cnt = cnt; b_down = down; b_oe = oe; b_drv = drv;
  endtask

  task automatic b_cycle(input logic en, rw, input logic [0:0] sel,
                         input logic cnt, down, oe, input logic [15:0] drv);
    b_set(en, rw, sel, cnt, down, oe, drv);
    @(posedge clk);
    #1;
  endtask

  task automatic b_peek(input logic [0:0] sel, output logic [15:0] val);
    b_set(1'b1, 1'b1, sel, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1 val = b_data;
  endtask

  initial begin
    logic [15:0] v;

    // Clock/reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      a_peek(3'(i), v);
      check_eq($sformatf("reset_rd%0d", i), v, 16'h0000);
    end
    check_eq("reset_direct", a_direct, 16'h0000);
    check_eq("reset_carry", 16'(a_carry), 16'h0000);

    // Load and drive
    a_cycle(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 16'h1234);
    a_peek(3'd2, v); check_eq("load_rd2", v, 16'h1234);
    a_peek(3'd1, v); check_eq("load_rd1_hold", v, 16'h0000);
    a_peek(3'd3, v); check_eq("load_rd3_hold", v, 16'h0000);
    check_eq("load_direct_hold", a_direct, 16'h0000);

    // Up count wrap and carry pulse
    a_cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    check_eq("load_direct", a_direct, 16'hFFFF);
    a_cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("up_wrap_val", a_direct, CNT ? 16'h0000 : 16'hFFFF);
    check_eq("up_wrap_carry", 16'(a_carry), 16'(CNT));
    a_peek(3'd0, v); check_eq("up_wrap_rd", v, CNT ? 16'h0000 : 16'hFFFF);
    check_eq("carry_held", 16'(a_carry), 16'(CNT));
    a_cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("carry_clear", 16'(a_carry), 16'h0000);
    a_cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("up_val", a_direct, CNT ? 16'h0001 : 16'hFFFF);
    check_eq("up_carry", 16'(a_carry), 16'h0000);

    // Count while driving: bus shows pre-count value
    a_set(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1 check_eq("drive_cnt_bus", a_data, CNT ? 16'h0001 : 16'hFFFF);
    @(posedge clk);
    #1 check_eq("drive_cnt_val", a_direct, CNT ? 16'h0002 : 16'hFFFF);

    // Down count borrow, then load beats count and clears carry
    a_cycle(1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_eq("down_borrow", 16'(a_carry), 16'(CNT));
    a_cycle(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 16'h00AA);
    check_eq("load_cnt_carry", 16'(a_carry), 16'h0000);
    a_peek(3'd3, v); check_eq("load_beats_cnt", v, 16'h00AA);
    a_peek(3'd1, v); check_eq("down_val", v, CNT ? 16'hFFFF : 16'h0000);

    // Out-of-range select
    a_cycle(1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    a_peek(3'd5, v); check_eq("sel5_rd", v, 16'h0000);
    a_peek(3'd4, v); check_eq("sel4_rd", v, 16'h0000);
    a_peek(3'd2, v); check_eq("sel5_rd2", v, 16'h1234);
    a_peek(3'd3, v); check_eq("sel5_rd3", v, 16'h00AA);
    check_eq("sel5_direct", a_direct, CNT ? 16'h0002 : 16'hFFFF);
    a_cycle(1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("up_wrap1_carry", 16'(a_carry), 16'(CNT));
    a_cycle(1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("sel5_cnt_carry", 16'(a_carry), 16'h0000);
    check_eq("sel5_cnt_direct", a_direct, CNT ? 16'h0002 : 16'hFFFF);
    a_peek(3'd1, v); check_eq("up_wrap1_val", v, 16'h0000);
    a_set(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // STEP=4 bank
    b_cycle(1'b1, 1'b0, 1'd1, 1'b0, 1'b0, 1'b1, 16'h0010);
    check_eq("b_load", b_direct, 16'h0010);
    b_cycle(1'b0, 1'b0, 1'd1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_eq("b_down4_val", b_direct, CNT ? 16'h000C : 16'h0010);
    check_eq("b_down4_carry", 16'(b_carry), 16'h0000);
    b_cycle(1'b1, 1'b0, 1'd1, 1'b0, 1'b0, 1'b1, 16'h0002);
    b_cycle(1'b0, 1'b0, 1'd1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_eq("b_borrow_val", b_direct, CNT ? 16'hFFFE : 16'h0002);
    check_eq("b_borrow_carry", 16'(b_carry), 16'(CNT));
    b_cycle(1'b1, 1'b0, 1'd0, 1'b0, 1'b0, 1'b1, 16'hFFFE);
    check_eq("b_other_hold", b_direct, CNT ? 16'hFFFE : 16'h0002);
    b_cycle(1'b0, 1'b0, 1'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("b_up_carry", 16'(b_carry), 16'(CNT));
    b_peek(1'd0, v); check_eq("b_up_val", v, CNT ? 16'h0002 : 16'hFFFE);
    b_cycle(1'b1, 1'b0, 1'd1, 1'b0, 1'b0, 1'b1, 16'h0004);
    b_cycle(1'b0, 1'b0, 1'd1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_eq("b_exact_val", b_direct, CNT ? 16'h0000 : 16'h0004);
    check_eq("b_exact_carry", 16'(b_carry), 16'h0000);
    b_set(1'b0, 1'b0, 1'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset wins over a pending load
    a_set(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 16'h5555);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_en = 1'b0; a_oe = 1'b0; a_cnt = 1'b0;
    a_peek(3'd3, v); check_eq("rst_pend_rd3", v, 16'h0000);
    a_peek(3'd2, v); check_eq("rst_pend_rd2", v, 16'h0000);
    check_eq("rst_pend_direct", a_direct, 16'h0000);
    check_eq("rst_pend_carry", 16'(a_carry), 16'h0000);
    check_eq("rst_b_direct", b_direct, 16'h0000);
    b_peek(1'd0, v); check_eq("rst_b_rd0", v, 16'h0000);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
